branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer for the fetch stage of the pipelined RV32 core. It is looked up in the same cycle as the Gshare predictor, using the fetch PC. On a hit it supplies a predicted target to the PC mux, so a taken prediction does not wait for the immediate adder. Entries are updated from the EX stage with resolved branch outcomes, and 2-bit hysteresis limits thrashing when branches alias to the same entry.

## Interface
Parameters:
- WIDTH, 32, address/data width
- ENTRIES, 64, number of entries (power of two, ≥4); IDX = log2(ENTRIES)

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- read_en  input  1  fetch-stage lookup valid (conditional branch decoded in F)
- PC_F  input  WIDTH  fetch PC
- hit_F  output  1  lookup hit
- target_F  output  WIDTH  predicted target; 0 when hit_F=0
- write_en  input  1  EX-stage update valid (conditional branch resolved)
- PC_EX  input  WIDTH  PC of resolved branch
- taken_EX  input  1  resolved direction
- target_EX  input  WIDTH  resolved taken target
- invalidate_all  input  1  clear every entry (e.g. on instruction-memory reload)
- lookup_count  output  32  number of cycles with read_en=1, saturating
- hit_count  output  32  number of cycles with hit_F=1, saturating

## Operation
- Address split:
  - index = PC[IDX+1:2]
  - tag = PC[WIDTH-1:IDX+2]
  - PC[1:0] ignored
- Entry contents: valid (1), tag, target (WIDTH), conf (2-bit unsigned).
- Lookup (combinational):
  - hit_F = read_en & valid[idx_F] & (tag[idx_F] == tag_F)
  - target_F = hit_F ? target[idx_F] : 0
- Update (registered, when write_en=1 and invalidate_all=0, indexed by PC_EX):
  - Valid entry, tag match, taken:
    - target ← target_EX
    - conf ← min(conf+1, 3)
  - Valid entry, tag match, not taken:
    - conf ≠ 0 → conf ← conf−1
    - conf = 0 → valid ← 0
  - Invalid entry, taken: allocate with valid=1, tag, target=target_EX, conf=1.
  - Invalid entry, not taken: no change.
  - Valid entry, tag mismatch, taken:
    - conf = 0 → replace (as allocate)
    - else → conf ← conf−1
  - Valid entry, tag mismatch, not taken: no change.
- invalidate_all=1:
  - All valid bits clear on the next edge.
  - Takes priority over write_en; the update is dropped.
- Counters: increment on the qualifying cycle, saturate at 0xFFFF_FFFF. They are not affected by invalidate_all.

## Timing
- Lookup latency: 0 cycles (combinational from PC_F/read_en).
- Update visibility: an update at edge N is visible to lookups from cycle N+1 onward.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents (read-before-write).
- Reset (rst=1 at an edge):
  - all valid ← 0, conf ← 0, tag/target ← 0
  - lookup_count ← 0, hit_count ← 0
  - hence hit_F=0 and target_F=0 from the cycle after reset
  - reset has priority over write_en and invalidate_all
  - reset mid-operation discards any concurrent update
- Every state change is gated by the clock edge; there is no asynchronous path.
- Outputs never go X after reset, including the unused tag bits of invalid entries.

## Test plan
ENTRIES=64. Addresses 0x104 and 0x204 both map to index 1, with tags 0x1 and 0x2.

1. **Reset state:** after reset, read_en=1, PC_F=0x100 → hit_F=0, target_F=0, lookup_count=1 on the next cycle, hit_count=0.
2. **Allocate then hit:** write_en=1, PC_EX=0x104, taken_EX=1, target_EX=0x200 → next cycle PC_F=0x104 gives hit_F=1, target_F=0x200; PC_F=0x204 gives hit_F=0.
3. **Aliasing hysteresis:** with the 0x104 entry at conf=1:
   - first update PC_EX=0x204, taken, target 0x300 → entry unchanged except conf=0; 0x104 still hits 0x200
   - second identical update → 0x204 hits 0x300, 0x104 misses
4. **Same-cycle lookup/update:** with 0x104→0x200 installed, PC_F=0x104 and an update PC_EX=0x104, taken, target 0x280 in the same cycle → target_F=0x200 that cycle, 0x280 the next.
5. **Not-taken decay:**
   - allocate 0x104 (conf=1)
   - not-taken update → still hits, conf=0
   - second not-taken → hit_F=0 next cycle
6. **Invalidate priority:** two entries installed; invalidate_all=1 together with a taken write_en to 0x308 → the next cycle every lookup (0x104, 0x204, 0x308) misses; counters retain their values.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational fetch-stage lookup, EX-stage update with
// 2-bit hysteresis so aliasing branches do not immediately evict each other.
module branch_target_buffer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic [WIDTH-1:0] PC_F,
  output logic             hit_F,
  output logic [WIDTH-1:0] target_F,
  input  logic             write_en,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic             taken_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             invalidate_all,
  output logic [31:0]      lookup_count,
  output logic [31:0]      hit_count
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = WIDTH - IDX - 2;

  logic             r_valid  [ENTRIES];
  logic [TW-1:0]    r_tag    [ENTRIES];
  logic [WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]       r_conf   [ENTRIES];
  logic [31:0]      r_lookup_count;
  logic [31:0]      r_hit_count;

  logic [IDX-1:0]   w_idx_f;
  logic [TW-1:0]    w_tag_f;
  logic [IDX-1:0]   w_idx_ex;
  logic [TW-1:0]    w_tag_ex;
  logic             w_hit;

  logic             w_new_valid;
  logic [TW-1:0]    w_new_tag;
  logic [WIDTH-1:0] w_new_target;
  logic [1:0]       w_new_conf;

  assign w_idx_f  = PC_F[IDX+1:2];
  assign w_tag_f  = PC_F[WIDTH-1:IDX+2];
  assign w_idx_ex = PC_EX[IDX+1:2];
  assign w_tag_ex = PC_EX[WIDTH-1:IDX+2];

  assign w_hit    = read_en & r_valid[w_idx_f] & (r_tag[w_idx_f] == w_tag_f);
  assign hit_F    = w_hit;
  assign target_F = w_hit ? r_target[w_idx_f] : '0;

  // Next contents of the entry addressed by PC_EX; defaults leave it unchanged.
  always_comb begin
    w_new_valid  = r_valid[w_idx_ex];
    w_new_tag    = r_tag[w_idx_ex];
    w_new_target = r_target[w_idx_ex];
    w_new_conf   = r_conf[w_idx_ex];
    if (!r_valid[w_idx_ex]) begin
      if (taken_EX) begin
        w_new_valid  = 1'b1;
        w_new_tag    = w_tag_ex;
        w_new_target = target_EX;
        w_new_conf   = 2'd1;
      end
    end else if (r_tag[w_idx_ex] == w_tag_ex) begin
      if (taken_EX) begin
        w_new_target = target_EX;
        if (r_conf[w_idx_ex] != 2'd3) w_new_conf = r_conf[w_idx_ex] + 2'd1;
      end else if (r_conf[w_idx_ex] != 2'd0) begin
        w_new_conf = r_conf[w_idx_ex] - 2'd1;
      end else begin
        w_new_valid = 1'b0;
      end
    end else if (taken_EX) begin
      // Aliasing branch only evicts once the resident entry has lost all confidence.
      if (r_conf[w_idx_ex] == 2'd0) begin
        w_new_valid  = 1'b1;
        w_new_tag    = w_tag_ex;
        w_new_target = target_EX;
        w_new_conf   = 2'd1;
      end else begin
        w_new_conf = r_conf[w_idx_ex] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_conf[i]   <= 2'd0;
      end
    end else if (invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (write_en) begin
      r_valid[w_idx_ex]  <= w_new_valid;
      r_tag[w_idx_ex]    <= w_new_tag;
      r_target[w_idx_ex] <= w_new_target;
      r_conf[w_idx_ex]   <= w_new_conf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lookup_count <= '0;
      r_hit_count    <= '0;
    end else begin
      if (read_en && r_lookup_count != 32'hFFFF_FFFF) r_lookup_count <= r_lookup_count + 32'd1;
      if (w_hit && r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
    end
  end

  assign lookup_count = r_lookup_count;
  assign hit_count    = r_hit_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, aliasing hysteresis, read-before-write,
// not-taken decay, invalidate and reset priority, counters.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [31:0] PC_F;
  logic        hit_F;
  logic [31:0] target_F;
  logic        write_en;
  logic [31:0] PC_EX;
  logic        taken_EX;
  logic [31:0] target_EX;
  logic        invalidate_all;
  logic [31:0] lookup_count;
  logic [31:0] hit_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.WIDTH(32), .ENTRIES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_en        (read_en),
    .PC_F           (PC_F),
    .hit_F          (hit_F),
    .target_F       (target_F),
    .write_en       (write_en),
    .PC_EX          (PC_EX),
    .taken_EX       (taken_EX),
    .target_EX      (target_EX),
    .invalidate_all (invalidate_all),
    .lookup_count   (lookup_count),
    .hit_count      (hit_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // In-cycle lookup; read_en is dropped again so no edge sees it.
  task automatic look(input string tag, input logic [31:0] pc, input logic h,
                      input logic [31:0] t);
    read_en = 1'b1;
    PC_F    = pc;
    #1;
    check_eq({tag, ".hit"}, {31'd0, hit_F}, {31'd0, h});
    check_eq({tag, ".tgt"}, target_F, t);
    read_en = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    write_en  = 1'b1;
    PC_EX     = pc;
    taken_EX  = tk;
    target_EX = tgt;
    step();
    write_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; PC_F = '0; write_en = 1'b0; PC_EX = '0;
    taken_EX = 1'b0; target_EX = '0; invalidate_all = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    read_en = 1'b1;
    PC_F    = 32'h100;
    #1;
    check_eq("rst.hit", {31'd0, hit_F}, 32'd0);
    check_eq("rst.tgt", target_F, 32'd0);
    check_eq("rst.lookups0", lookup_count, 32'd0);
    step();
    read_en = 1'b0;
    check_eq("rst.lookups1", lookup_count, 32'd1);
    check_eq("rst.hits", hit_count, 32'd0);

    // Allocate then hit
    upd(32'h104, 1'b1, 32'h200);
    look("alloc.104", 32'h104, 1'b1, 32'h200);
    look("alloc.204", 32'h204, 1'b0, 32'h0);

    // Aliasing hysteresis
    upd(32'h204, 1'b1, 32'h300);
    look("alias1.104", 32'h104, 1'b1, 32'h200);
    look("alias1.204", 32'h204, 1'b0, 32'h0);
    upd(32'h204, 1'b1, 32'h300);
    look("alias2.204", 32'h204, 1'b1, 32'h300);
    look("alias2.104", 32'h104, 1'b0, 32'h0);

    // Reinstall 0x104 -> 0x200 (decay 0x204 to conf 0, then replace)
    upd(32'h104, 1'b1, 32'h200);
    look("reins1.204", 32'h204, 1'b1, 32'h300);
    upd(32'h104, 1'b1, 32'h200);
    look("reins2.104", 32'h104, 1'b1, 32'h200);

    // Same-cycle lookup/update: read-before-write
    read_en   = 1'b1;
    PC_F      = 32'h104;
    write_en  = 1'b1;
    PC_EX     = 32'h104;
    taken_EX  = 1'b1;
    target_EX = 32'h280;
    #1;
    check_eq("rbw.old", target_F, 32'h200);
    step();
    write_en = 1'b0;
    check_eq("rbw.new", target_F, 32'h280);
    read_en = 1'b0;
    check_eq("rbw.lookups", lookup_count, 32'd2);
    check_eq("rbw.hits", hit_count, 32'd1);

    // Not-taken decay from conf=2
    upd(32'h104, 1'b0, 32'h0);
    look("nt.c1", 32'h104, 1'b1, 32'h280);
    upd(32'h104, 1'b0, 32'h0);
    look("nt.c0", 32'h104, 1'b1, 32'h280);
    upd(32'h104, 1'b0, 32'h0);
    look("nt.gone", 32'h104, 1'b0, 32'h0);
    upd(32'h104, 1'b0, 32'h0);
    look("nt.inv_nochange", 32'h104, 1'b0, 32'h0);
    // Fresh allocation at conf=1 decays in two not-taken updates
    upd(32'h104, 1'b1, 32'h180);
    look("nt2.alloc", 32'h104, 1'b1, 32'h180);
    upd(32'h104, 1'b0, 32'h0);
    look("nt2.c0", 32'h104, 1'b1, 32'h180);
    upd(32'h104, 1'b0, 32'h0);
    look("nt2.gone", 32'h104, 1'b0, 32'h0);

    // Invalidate has priority over a concurrent update
    upd(32'h104, 1'b1, 32'h200);
    upd(32'h210, 1'b1, 32'h500);
    look("inv.pre104", 32'h104, 1'b1, 32'h200);
    look("inv.pre210", 32'h210, 1'b1, 32'h500);
    invalidate_all = 1'b1;
    upd(32'h308, 1'b1, 32'h400);
    invalidate_all = 1'b0;
    look("inv.104", 32'h104, 1'b0, 32'h0);
    look("inv.204", 32'h204, 1'b0, 32'h0);
    look("inv.308", 32'h308, 1'b0, 32'h0);
    look("inv.210", 32'h210, 1'b0, 32'h0);
    check_eq("inv.lookups", lookup_count, 32'd2);
    check_eq("inv.hits", hit_count, 32'd1);

    // Reset has priority over a concurrent update and clears the counters
    upd(32'h104, 1'b1, 32'h200);
    look("rst2.pre", 32'h104, 1'b1, 32'h200);
    rst = 1'b1;
    upd(32'h308, 1'b1, 32'h400);
    rst = 1'b0;
    look("rst2.104", 32'h104, 1'b0, 32'h0);
    look("rst2.308", 32'h308, 1'b0, 32'h0);
    check_eq("rst2.lookups", lookup_count, 32'd0);
    check_eq("rst2.hits", hit_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
